compli_discrepancy_monitor: RTL and testbench

//  Consumes a complementary safety pair (complimentary_bit::compli, p/n) from an external dual-channel input.

---
 rtl/compli_discrepancy_monitor.sv | 178 +++++++++++++++++
 tb/tb_compli_discrepancy_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/compli_discrepancy_monitor.sv
// ---------------------------------------------------------------------------
// compli_discrepancy_monitor
//
// Monitors a complementary safety pair {p,n} from an external dual-channel
// input. Both bits are synchronised, transient p==n discrepancies are
// filtered by a bounded discrepancy timer, and a persistent discrepancy
// latches a fault. en_o is asserted only while the monitor is in RUN, which
// requires a valid run pair and a prior arming by a valid stop pair.
//
// Optional feature macro: COMPLI_MON_DIAG_CNT_EN
//   When defined, adds diag_cnt_o, an 8-bit saturating count of STOP/RUN ->
//   DISC entries, cleared only by rst.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   pn_i        {p,n} pair, asynchronous to clk
//   fault_clr   fault acknowledge pulse
//   en_o        registered enable (state RUN)
//   fault_o     latched discrepancy fault
//   state_o     FSM state: STOP=00 RUN=01 DISC=10 FAULT=11
//   disc_cnt_o  discrepancy counter
//   diag_cnt_o  discrepancy event counter (COMPLI_MON_DIAG_CNT_EN only)
// ---------------------------------------------------------------------------
module compli_discrepancy_monitor #(
  parameter int unsigned DISC_TIME   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CNT_W      = $clog2(DISC_TIME + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pn_i,
  input  logic             fault_clr,
  output logic             en_o,
  output logic             fault_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] disc_cnt_o
`ifdef COMPLI_MON_DIAG_CNT_EN
  ,
  output logic [7:0]       diag_cnt_o
`endif
);

  if (DISC_TIME < 2) begin : g_chk_disc_time
    $error("DISC_TIME must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync_stages
    $error("SYNC_STAGES must be >= 2");
  end

  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DISC  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISC_TIME - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES-1:0] sync_n;
  logic [SYNC_STAGES-1:0] sync_fill;
  logic                   sync_full;
  logic [1:0]             pair;
  logic                   pair_run;
  logic                   pair_stop;
  logic                   pair_bad;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;
  logic             armed_nxt;
  logic             disc_entry;

  // Synchroniser chains reset to the stop pair 01. sync_fill marks when the
  // chain holds only real pin samples; the reset-value 01 must not arm the
  // monitor, otherwise a run pair present straight out of reset would enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p    <= '0;
      sync_n    <= '1;
      sync_fill <= '0;
    end else begin
      sync_p    <= {sync_p[SYNC_STAGES-2:0], pn_i[1]};
      sync_n    <= {sync_n[SYNC_STAGES-2:0], pn_i[0]};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_full = sync_fill[SYNC_STAGES-1];
  assign pair      = {sync_p[SYNC_STAGES-1], sync_n[SYNC_STAGES-1]};
  assign pair_run  = (pair == 2'b10);
  assign pair_stop = (pair == 2'b01);
  assign pair_bad  = (pair[1] == pair[0]);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    armed_nxt  = armed;
    disc_entry = 1'b0;
    case (state)
      ST_STOP: begin
        if (pair_bad) begin
          state_nxt  = ST_DISC;
          cnt_nxt    = CNT_W'(1);
          armed_nxt  = 1'b0;
          disc_entry = 1'b1;
        end else if (pair_run && armed) begin
          state_nxt = ST_RUN;
        end else if (pair_stop && sync_full) begin
          armed_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (pair_bad) begin
          state_nxt  = ST_DISC;
          cnt_nxt    = CNT_W'(1);
          armed_nxt  = 1'b0;
          disc_entry = 1'b1;
        end else if (pair_stop) begin
          state_nxt = ST_STOP;
        end
      end
      ST_DISC: begin
        if (pair_bad) begin
          if (cnt == CNT_LAST) begin
            state_nxt = ST_FAULT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          // Any valid pair leaves through STOP; a run pair cannot re-enter
          // RUN until a stop pair re-arms.
          state_nxt = ST_STOP;
          cnt_nxt   = '0;
        end
      end
      default: begin
        cnt_nxt = '0;
        if (fault_clr && pair_stop) begin
          state_nxt = ST_STOP;
          armed_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_STOP;
      cnt     <= '0;
      armed   <= 1'b0;
      en_o    <= 1'b0;
      fault_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      armed   <= armed_nxt;
      en_o    <= (state_nxt == ST_RUN);
      fault_o <= (state_nxt == ST_FAULT);
    end
  end

  assign state_o    = state;
  assign disc_cnt_o = cnt;

`ifdef COMPLI_MON_DIAG_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      diag_cnt_o <= '0;
    end else if (disc_entry && (diag_cnt_o != 8'hFF)) begin
      diag_cnt_o <= diag_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_compli_discrepancy_monitor.sv
// ---------------------------------------------------------------------------
// tb_compli_discrepancy_monitor
//
// Directed, table-driven bench for compli_discrepancy_monitor with
// DISC_TIME=8, SYNC_STAGES=2. Each table row gives the inputs applied for
// one clock and the outputs expected just after that clock. Hand-written
// sequences cover the toggling-BAD fault path, fault clear, and (when
// COMPLI_MON_DIAG_CNT_EN is defined) the diagnostic counter.
// ---------------------------------------------------------------------------
module tb_compli_discrepancy_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pn;
  logic       fault_clr;
  logic       en;
  logic       fault;
  logic [1:0] st;
  logic [3:0] cnt;
`ifdef COMPLI_MON_DIAG_CNT_EN
  logic [7:0] diag_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  compli_discrepancy_monitor #(
    .DISC_TIME  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pn_i      (pn),
    .fault_clr (fault_clr),
    .en_o      (en),
    .fault_o   (fault),
    .state_o   (st),
    .disc_cnt_o(cnt)
`ifdef COMPLI_MON_DIAG_CNT_EN
    ,
    .diag_cnt_o(diag_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] pn;
    logic       clr;
    logic       en;
    logic       fault;
    logic [1:0] st;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] p, input logic c,
                     input logic e, input logic f, input logic [1:0] s,
                     input logic [3:0] n);
    vec_t v;
    v.rst = r; v.pn = p; v.clr = c; v.en = e; v.fault = f; v.st = s; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic diag_entry();
    pn = 2'b00; step();
    pn = 2'b01; step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    rst = 1'b1; pn = 2'b01; fault_clr = 1'b0;

    //   rst  pn    clr  en  flt st     cnt
    // reset, arm with 01, run 3 cycles after 10 applied
    add(1, 2'b01, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b01, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b01, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b01, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   1,  0,  2'd1, 4'd0);
    // 7 BAD (11) then valid: DISC 1..7, back to STOP, no fault
    add(0, 2'b11, 0,   1,  0,  2'd1, 4'd0);
    add(0, 2'b11, 0,   1,  0,  2'd1, 4'd0);
    add(0, 2'b11, 0,   0,  0,  2'd2, 4'd1);
    add(0, 2'b11, 0,   0,  0,  2'd2, 4'd2);
    add(0, 2'b11, 0,   0,  0,  2'd2, 4'd3);
    add(0, 2'b11, 0,   0,  0,  2'd2, 4'd4);
    add(0, 2'b11, 0,   0,  0,  2'd2, 4'd5);
    add(0, 2'b01, 0,   0,  0,  2'd2, 4'd6);
    add(0, 2'b01, 0,   0,  0,  2'd2, 4'd7);
    add(0, 2'b01, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   1,  0,  2'd1, 4'd0);
    add(0, 2'b10, 0,   1,  0,  2'd1, 4'd0);
    // 8 BAD (00): FAULT on the 8th synced sample; run pair keeps FAULT
    add(0, 2'b00, 0,   1,  0,  2'd1, 4'd0);
    add(0, 2'b00, 0,   1,  0,  2'd1, 4'd0);
    add(0, 2'b00, 0,   0,  0,  2'd2, 4'd1);
    add(0, 2'b00, 0,   0,  0,  2'd2, 4'd2);
    add(0, 2'b00, 0,   0,  0,  2'd2, 4'd3);
    add(0, 2'b00, 0,   0,  0,  2'd2, 4'd4);
    add(0, 2'b00, 0,   0,  0,  2'd2, 4'd5);
    add(0, 2'b00, 0,   0,  0,  2'd2, 4'd6);
    add(0, 2'b10, 0,   0,  0,  2'd2, 4'd7);
    add(0, 2'b10, 0,   0,  1,  2'd3, 4'd0);
    add(0, 2'b10, 0,   0,  1,  2'd3, 4'd0);
    // clear with run pair ignored and not stored; clear with stop pair exits
    add(0, 2'b10, 1,   0,  1,  2'd3, 4'd0);
    add(0, 2'b01, 0,   0,  1,  2'd3, 4'd0);
    add(0, 2'b01, 0,   0,  1,  2'd3, 4'd0);
    add(0, 2'b01, 0,   0,  1,  2'd3, 4'd0);
    add(0, 2'b01, 1,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   1,  0,  2'd1, 4'd0);
    // clear outside FAULT has no effect; BAD toggling 11/00 counts on
    add(0, 2'b10, 1,   1,  0,  2'd1, 4'd0);
    add(0, 2'b11, 0,   1,  0,  2'd1, 4'd0);
    add(0, 2'b00, 0,   1,  0,  2'd1, 4'd0);
    add(0, 2'b11, 0,   0,  0,  2'd2, 4'd1);
    add(0, 2'b00, 0,   0,  0,  2'd2, 4'd2);
    add(0, 2'b11, 0,   0,  0,  2'd2, 4'd3);
    add(0, 2'b00, 0,   0,  0,  2'd2, 4'd4);
    add(0, 2'b11, 0,   0,  0,  2'd2, 4'd5);
    // reset at DISC cnt=5 wins; afterwards unarmed, run pair stays STOP
    add(1, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b01, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   0,  0,  2'd0, 4'd0);
    add(0, 2'b10, 0,   1,  0,  2'd1, 4'd0);

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      pn        = vecs[i].pn;
      fault_clr = vecs[i].clr;
      step();
      check($sformatf("vec%0d {en,fault,state,cnt}", i),
            {24'd0, en, fault, st, cnt},
            {24'd0, vecs[i].en, vecs[i].fault, vecs[i].st, vecs[i].cnt});
    end
    rst = 1'b0; fault_clr = 1'b0;

    // From RUN, toggling 00/11: first BAD seen after 3 clocks, FAULT after 10.
    cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      pn = (k % 2 == 1) ? 2'b00 : 2'b11;
      step();
      if (fault === 1'b1) begin
        cycles = k;
        break;
      end
    end
    check("toggle_bad_fault_latency", cycles, 10);
    check("toggle_bad_fault_state", {30'd0, st}, 32'd3);
    check("toggle_bad_fault_en", {31'd0, en}, 32'd0);

    pn = 2'b01;
    step(); step(); step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("clear_fault_state", {30'd0, st}, 32'd0);
    check("clear_fault_flag", {31'd0, fault}, 32'd0);

`ifdef COMPLI_MON_DIAG_CNT_EN
    rst = 1'b1; pn = 2'b01;
    step();
    rst = 1'b0;
    check("diag_reset", {24'd0, diag_cnt}, 32'd0);
    step(); step(); step();
    for (int k = 0; k < 3; k++) diag_entry();
    pn = 2'b01;
    step(); step(); step(); step();
    check("diag_three_entries", {24'd0, diag_cnt}, 32'd3);
    for (int k = 0; k < 297; k++) diag_entry();
    pn = 2'b01;
    step(); step(); step(); step();
    check("diag_saturate", {24'd0, diag_cnt}, 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
